// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for the two-input round-robin mux arbiter.
interface mux_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             last0;
  logic             last1;
  logic             y_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             sel;
  logic             gnt0;
  logic             gnt1;
  logic             ack0;
  logic             ack1;

  // Requesters plus downstream sink.
  modport master (
    output req0, req1, data0, data1, last0, last1, y_ready,
    input  y_valid, y_data, sel, gnt0, gnt1, ack0, ack1
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, data0, data1, last0, last1, y_ready,
    output y_valid, y_data, sel, gnt0, gnt1, ack0, ack1
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter with burst limiting and a 2:1 data mux.
// Grant/select come from state only; valid/ack/data follow the granted
// requester combinationally so a beat transfers in the grant cycle.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst,
  mux_rr_arbiter_if.slave bus
);
  localparam int unsigned        CNT_W     = 4;
  localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             r_last_grant;
  logic             w_last_grant_nxt;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_valid;
  logic             w_ack0;
  logic             w_ack1;
  logic [WIDTH-1:0] w_y_data;

  logic             w_req_own;
  logic             w_req_oth;
  logic             w_last_own;
  logic             w_ack_own;
  logic             w_release;

  // Decode grants from state; valid/ack qualify with the live request.
  assign w_gnt0   = (r_state == GRANT0);
  assign w_gnt1   = (r_state == GRANT1);
  assign w_valid  = (w_gnt0 & bus.req0) | (w_gnt1 & bus.req1);
  assign w_ack0   = w_gnt0 & bus.req0 & bus.y_ready;
  assign w_ack1   = w_gnt1 & bus.req1 & bus.y_ready;
  assign w_y_data = w_gnt1 ? bus.data1 : bus.data0;

  assign bus.gnt0    = w_gnt0;
  assign bus.gnt1    = w_gnt1;
  assign bus.sel     = w_gnt1;
  assign bus.y_valid = w_valid;
  assign bus.ack0    = w_ack0;
  assign bus.ack1    = w_ack1;
  assign bus.y_data  = w_y_data;

  // Signals seen from the currently granted requester's point of view.
  assign w_req_own  = w_gnt1 ? bus.req1  : bus.req0;
  assign w_req_oth  = w_gnt1 ? bus.req0  : bus.req1;
  assign w_last_own = w_gnt1 ? bus.last1 : bus.last0;
  assign w_ack_own  = w_ack0 | w_ack1;

  // Beat count after this cycle's ack, saturating at the burst limit.
  assign w_cnt_sat = (r_cnt >= BURST_MAX) ? BURST_MAX : (r_cnt + CNT_W'(1));

  // Give up the grant on packet end, request drop, or burst limit with contention.
  assign w_release = !w_req_own
                   | (w_ack_own & w_last_own)
                   | (w_ack_own & w_req_oth & (w_cnt_sat == BURST_MAX));

  // Next-state, burst counter and round-robin pointer.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    unique case (r_state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || r_last_grant)) begin
          w_state_nxt      = GRANT0;
          w_cnt_nxt        = '0;
          w_last_grant_nxt = 1'b0;
        end else if (bus.req1) begin
          w_state_nxt      = GRANT1;
          w_cnt_nxt        = '0;
          w_last_grant_nxt = 1'b1;
        end
      end
      GRANT0: begin
        if (w_release) begin
          if (bus.req1) begin
            w_state_nxt      = GRANT1;
            w_cnt_nxt        = '0;
            w_last_grant_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_ack0) begin
          w_cnt_nxt = w_cnt_sat;
        end
      end
      GRANT1: begin
        if (w_release) begin
          if (bus.req0) begin
            w_state_nxt      = GRANT0;
            w_cnt_nxt        = '0;
            w_last_grant_nxt = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_ack1) begin
          w_cnt_nxt = w_cnt_sat;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State registers; reset leaves requester 0 as winner of the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural ownership model.
module tb_mux_rr_arbiter;
  localparam int unsigned WIDTH = 8;
  localparam int          MAXB  = 4;

  typedef logic [WIDTH+5:0] obs_t;  // {gnt0,gnt1,sel,y_valid,ack0,ack1,y_data}

  typedef struct {
    logic             r0;
    logic             r1;
    logic             l0;
    logic             l1;
    logic             yr;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    obs_t             exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             t_req0, t_req1, t_last0, t_last1, t_yr;
  logic [WIDTH-1:0] t_d0, t_d1;

  mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  assign bus.req0    = t_req0;
  assign bus.req1    = t_req1;
  assign bus.last0   = t_last0;
  assign bus.last1   = t_last1;
  assign bus.y_ready = t_yr;
  assign bus.data0   = t_d0;
  assign bus.data1   = t_d1;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the output, beats taken, who won last.
  int m_owner;  // -1 none, 0 or 1
  int m_beats;
  int m_prev;

  function automatic obs_t exp_o(input logic g0, input logic g1, input logic v,
                                 input logic a0, input logic a1,
                                 input logic [WIDTH-1:0] y);
    return {g0, g1, g1, v, a0, a1, y};
  endfunction

  function automatic vec_t mk(input logic r0, input logic r1, input logic l0,
                              input logic l1, input logic yr, input obs_t e);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.yr = yr;
    v.d0 = 8'h11; v.d1 = 8'hA5; v.exp = e;
    return v;
  endfunction

  function automatic obs_t dut_obs();
    return {bus.gnt0, bus.gnt1, bus.sel, bus.y_valid, bus.ack0, bus.ack1, bus.y_data};
  endfunction

  function automatic obs_t model_obs();
    logic g0, g1;
    g0 = (m_owner == 0);
    g1 = (m_owner == 1);
    return {g0, g1, g1, (g0 & t_req0) | (g1 & t_req1),
            g0 & t_req0 & t_yr, g1 & t_req1 & t_yr, g1 ? t_d1 : t_d0};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_prev  = 1;
  endtask

  // Advance the model by one accepted clock edge using the applied inputs.
  task automatic model_step();
    logic rq[2];
    logic lt[2];
    int   n, o, w;
    logic leave;
    rq[0] = t_req0;  rq[1] = t_req1;
    lt[0] = t_last0; lt[1] = t_last1;
    if (m_owner < 0) begin
      w = -1;
      if (rq[0] && rq[1])  w = 1 - m_prev;
      else if (rq[0])      w = 0;
      else if (rq[1])      w = 1;
      if (w >= 0) begin
        m_owner = w; m_beats = 0; m_prev = w;
      end
    end else begin
      n = m_owner;
      o = 1 - n;
      leave = !rq[n];
      if (rq[n] && t_yr) begin
        if (m_beats < MAXB) m_beats++;
        if (lt[n] || (m_beats == MAXB && rq[o])) leave = 1'b1;
      end
      if (leave) begin
        if (rq[o]) begin
          m_owner = o; m_beats = 0; m_prev = o;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = dut_obs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (gnt0,gnt1,sel,y_valid,ack0,ack1,y_data)",
               name, act, exp);
    end
  endtask

  task automatic set_in(input logic r0, input logic r1, input logic l0, input logic l1,
                        input logic yr, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1);
    t_req0 = r0; t_req1 = r1; t_last0 = l0; t_last1 = l1; t_yr = yr;
    t_d0 = d0; t_d1 = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  // Hold reset with requests pending, check quiet outputs, release idle.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 1, 0, 0, 1, 8'h5A, 8'hA5);
    #1 check("reset_outputs", exp_o(0, 0, 0, 0, 0, 8'h5A));
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_in(0, 0, 0, 0, 1, 8'h00, 8'h00);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl[16];

  initial begin
    set_in(0, 0, 0, 0, 0, 8'h00, 8'h00);
    model_reset();

    tbl[0]  = mk(0, 0, 0, 0, 1, exp_o(0, 0, 0, 0, 0, 8'h11));
    tbl[1]  = mk(0, 1, 0, 0, 1, exp_o(0, 0, 0, 0, 0, 8'h11));
    tbl[2]  = mk(0, 1, 0, 0, 1, exp_o(0, 1, 1, 0, 1, 8'hA5));
    tbl[3]  = mk(0, 1, 0, 1, 1, exp_o(0, 1, 1, 0, 1, 8'hA5));
    tbl[4]  = mk(0, 0, 0, 0, 1, exp_o(0, 0, 0, 0, 0, 8'h11));
    tbl[5]  = mk(1, 1, 0, 0, 1, exp_o(0, 0, 0, 0, 0, 8'h11));
    tbl[6]  = mk(1, 1, 0, 0, 0, exp_o(1, 0, 1, 0, 0, 8'h11));
    tbl[7]  = mk(1, 1, 0, 0, 0, exp_o(1, 0, 1, 0, 0, 8'h11));
    tbl[8]  = mk(1, 1, 0, 0, 1, exp_o(1, 0, 1, 1, 0, 8'h11));
    tbl[9]  = mk(1, 1, 0, 0, 1, exp_o(1, 0, 1, 1, 0, 8'h11));
    tbl[10] = mk(1, 1, 0, 0, 1, exp_o(1, 0, 1, 1, 0, 8'h11));
    tbl[11] = mk(1, 1, 0, 0, 1, exp_o(1, 0, 1, 1, 0, 8'h11));
    tbl[12] = mk(1, 1, 0, 0, 1, exp_o(0, 1, 1, 0, 1, 8'hA5));
    tbl[13] = mk(1, 0, 0, 0, 1, exp_o(0, 1, 0, 0, 0, 8'hA5));
    tbl[14] = mk(1, 0, 1, 0, 1, exp_o(1, 0, 1, 1, 0, 8'h11));
    tbl[15] = mk(0, 0, 0, 0, 1, exp_o(0, 0, 0, 0, 0, 8'h11));

    // Vector table from a fresh reset.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_in(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].yr, tbl[i].d0, tbl[i].d1);
      #1 check($sformatf("vec%0d", i), tbl[i].exp);
      tick();
    end

    // Both requesting continuously: 4-beat bursts alternate, requester 0 first.
    reset_dut();
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      set_in(1, 1, 0, 0, 1, 8'h3C, 8'hC3);
      if (k == 0) begin
        #1 check("alt_idle", exp_o(0, 0, 0, 0, 0, 8'h3C));
      end else if ((((k - 1) / MAXB) % 2) == 0) begin
        #1 check($sformatf("alt_k%0d", k), exp_o(1, 0, 1, 1, 0, 8'h3C));
      end else begin
        #1 check($sformatf("alt_k%0d", k), exp_o(0, 1, 1, 0, 1, 8'hC3));
      end
      tick();
    end

    // Backpressure stalls grant 0 for 5 cycles, then exactly 4 beats before handover.
    reset_dut();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      set_in(1, 1, 0, 0, (k >= 6), 8'h21, 8'h12);
      if (k == 0)      begin #1 check("stall_idle", exp_o(0, 0, 0, 0, 0, 8'h21)); end
      else if (k <= 5) begin #1 check($sformatf("stall_k%0d", k), exp_o(1, 0, 1, 0, 0, 8'h21)); end
      else if (k <= 9) begin #1 check($sformatf("stall_k%0d", k), exp_o(1, 0, 1, 1, 0, 8'h21)); end
      else             begin #1 check("stall_handover", exp_o(0, 1, 1, 0, 1, 8'h12)); end
      tick();
    end

    // Lone requester keeps its grant past the burst limit.
    reset_dut();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      set_in(1, 0, 0, 0, 1, 8'h77, 8'h88);
      if (k == 0) begin #1 check("solo_idle", exp_o(0, 0, 0, 0, 0, 8'h77)); end
      else        begin #1 check($sformatf("solo_k%0d", k), exp_o(1, 0, 1, 1, 0, 8'h77)); end
      tick();
    end

    // Asynchronous reset mid-GRANT1 quiets outputs before any edge.
    reset_dut();
    @(negedge clk);
    set_in(0, 1, 0, 0, 1, 8'h44, 8'h99);
    #1 check("arst_idle", exp_o(0, 0, 0, 0, 0, 8'h44));
    tick();
    @(negedge clk);
    #1 check("arst_grant1", exp_o(0, 1, 1, 0, 1, 8'h99));
    #2 rst = 1'b1;
    #1 check("arst_immediate", exp_o(0, 0, 0, 0, 0, 8'h44));
    model_reset();
    @(negedge clk);
    set_in(1, 1, 0, 0, 1, 8'h44, 8'h99);
    rst = 1'b0;
    #1 check("arst_release_idle", exp_o(0, 0, 0, 0, 0, 8'h44));
    tick();
    @(negedge clk);
    #1 check("arst_first_grant0", exp_o(1, 0, 1, 1, 0, 8'h44));
    tick();

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      set_in(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) < 7), WIDTH'($urandom), WIDTH'($urandom));
      #1 check($sformatf("rand_c%0d", c), model_obs());
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
